spi_flash_responder: RTL

Synthesizable responder for the byte-wide SPI link driven by the APB NOR-flash controller. It decodes 8-byte frames: command, 3 address bytes, 4 data bytes MSB-first. WRITE frames are stored into a small word array and READ frames are returned on `s_miso`. It stands in for the external NOR device in FPGA bring-up and system simulation, on the `p_clk` domain that generates `s_clk`.

---
 rtl/spi_flash_pkg.sv | 16 +
 rtl/spi_byte_strobe.sv | 34 +++
 rtl/spi_flash_responder.sv | 132 +++++++++++++
 3 files changed

// File: rtl/spi_flash_pkg.sv
// Shared constants and state encoding for the SPI flash responder.
package spi_flash_pkg;

    localparam logic [7:0] CMD_WRITE   = 8'h02;
    localparam logic [7:0] CMD_READ    = 8'h01;
    localparam int         FRAME_BYTES = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_DRAIN
    } flash_state_t;

endpackage

// File: rtl/spi_byte_strobe.sv
// Turns the p_clk-synchronous s_clk / s_css levels into single-cycle edge, select and deselect strobes.
module spi_byte_strobe (
    input  logic clk,
    input  logic reset,
    input  logic s_clk,
    input  logic s_css,
    output logic clk_edge,
    output logic sel,
    output logic desel
);

    logic s_clk_q;
    logic s_css_q;
    logic armed;

    // armed stays low while chip select has been low since reset, so a select
    // already held across reset release cannot start a frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_clk_q <= 1'b0;
            s_css_q <= 1'b1;
            armed   <= s_css;
        end else begin
            s_clk_q <= s_clk;
            s_css_q <= s_css;
            armed   <= armed | s_css;
        end
    end

    assign clk_edge = s_clk & ~s_clk_q;
    assign sel      = ~s_css & s_css_q & armed;
    assign desel    = s_css & ~s_css_q;

endmodule

// File: rtl/spi_flash_responder.sv
// NOR-flash stand-in: decodes 8-byte command/address/data frames into a small word array.
//   state    | meaning
//   ST_IDLE  | waiting for chip select
//   ST_CMD   | next edge carries the command byte
//   ST_ADDR  | collecting the three address bytes
//   ST_DATA  | four data bytes, written or returned
//   ST_DRAIN | frame finished or rejected, ignore edges until deselect
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int MEM_WORDS = 16
) (
    input  logic       p_clk,
    input  logic       p_reset,
    input  logic       s_css,
    input  logic       s_clk,
    input  logic [7:0] s_mosi,
    output logic [7:0] s_miso,
    output logic       busy,
    output logic       frame_err
);

    localparam int AW = $clog2(MEM_WORDS);

    flash_state_t state;
    logic [7:0]   cmd;
    logic [23:0]  addr;
    logic [1:0]   acnt;
    logic [1:0]   dcnt;
    logic [23:0]  wr_word;
    logic [31:0]  rd_word;
    logic [31:0]  mem [MEM_WORDS];

    logic clk_edge, sel, desel;

    spi_byte_strobe u_strobe (
        .clk      (p_clk),
        .reset    (p_reset),
        .s_clk    (s_clk),
        .s_css    (s_css),
        .clk_edge (clk_edge),
        .sel      (sel),
        .desel    (desel)
    );

    // The third address byte arrives on s_mosi, so the read lookup uses it directly.
    logic [23:0]   next_addr;
    logic [AW-1:0] idx, nxt_idx;
    logic          in_range, nxt_in_range, is_read;

    assign next_addr    = {addr[23:8], s_mosi};
    assign idx          = addr[AW-1:0];
    assign nxt_idx      = next_addr[AW-1:0];
    assign in_range     = (addr[23:AW] == '0);
    assign nxt_in_range = (next_addr[23:AW] == '0);
    assign is_read      = (cmd == CMD_READ);
    assign busy         = (state != ST_IDLE);

    always_ff @(posedge p_clk) begin
        if (p_reset) begin
            state     <= ST_IDLE;
            cmd       <= 8'h00;
            addr      <= 24'h0;
            acnt      <= 2'd0;
            dcnt      <= 2'd0;
            wr_word   <= 24'h0;
            rd_word   <= 32'hFFFF_FFFF;
            s_miso    <= 8'h00;
            frame_err <= 1'b0;
            for (int i = 0; i < MEM_WORDS; i++) mem[i] <= 32'hFFFF_FFFF;
        end else begin
            frame_err <= 1'b0;
            if (desel) begin
                if (state == ST_CMD || state == ST_ADDR || state == ST_DATA) frame_err <= 1'b1;
                state  <= ST_IDLE;
                s_miso <= 8'h00;
            end else begin
                case (state)
                    ST_IDLE: begin
                        s_miso <= 8'h00;
                        if (sel) state <= ST_CMD;
                    end
                    ST_CMD: if (clk_edge) begin
                        if (s_mosi == CMD_WRITE || s_mosi == CMD_READ) begin
                            cmd   <= s_mosi;
                            acnt  <= 2'd0;
                            state <= ST_ADDR;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= ST_DRAIN;
                        end
                    end
                    ST_ADDR: if (clk_edge) begin
                        acnt <= acnt + 2'd1;
                        case (acnt)
                            2'd0:    addr[23:16] <= s_mosi;
                            2'd1:    addr[15:8]  <= s_mosi;
                            default: begin
                                addr[7:0] <= s_mosi;
                                dcnt      <= 2'd0;
                                state     <= ST_DATA;
                                if (is_read) begin
                                    rd_word <= nxt_in_range ? mem[nxt_idx] : 32'hFFFF_FFFF;
                                    s_miso  <= nxt_in_range ? mem[nxt_idx][31:24] : 8'hFF;
                                end
                            end
                        endcase
                    end
                    ST_DATA: if (clk_edge) begin
                        dcnt    <= dcnt + 2'd1;
                        wr_word <= {wr_word[15:0], s_mosi};
                        if (is_read) begin
                            case (dcnt)
                                2'd0:    s_miso <= rd_word[23:16];
                                2'd1:    s_miso <= rd_word[15:8];
                                2'd2:    s_miso <= rd_word[7:0];
                                default: s_miso <= 8'h00;
                            endcase
                        end
                        if (dcnt == 2'd3) begin
                            state <= ST_DRAIN;
                            if (!is_read && in_range) mem[idx] <= {wr_word, s_mosi};
                        end
                    end
                    ST_DRAIN: s_miso <= 8'h00;
                    default:  state  <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
